parking_gate_ctrl: RTL and testbench
====================================

# parking_gate_ctrl

Gate-side controller that produces the per-car event pulses consumed by the parking occupancy/clock block. It debounces the gate's two loop detectors, reads a card reader (university or public), and on an entry gate checks the occupancy block's space-available flags. It then drives the barrier and emits exactly one single-cycle car event per completed passage. One instance sits at each entry gate and each exit gate.

## Interface
Parameters:
- IS_ENTRY, 1, 1 = entry gate (space check enforced); 0 = exit gate (no space check)
- DEBOUNCE_CYCLES, 4, consecutive stable samples needed before a loop input changes state (≥1)
- PASS_TIMEOUT, 200, clocks allowed in OPEN for a car to reach the outer loop (≥1)

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clock only
- loop_in  in  1  raw approach-loop detector, car waiting at barrier
- loop_out  in  1  raw far-side loop detector, car passing barrier
- card_valid  in  1  one-cycle strobe from card reader
- card_is_uni  in  1  card class, valid with card_valid
- space_uni  in  1  university space available (from occupancy block)
- space_public  in  1  public space available (from occupancy block)
- barrier_open  out  1  barrier drive, level
- car_event  out  1  one-cycle pulse per completed passage; wire to car_entered/car_exited
- is_uni_event  out  1  class of passage, valid only while car_event=1, else 0
- rejected  out  1  one-cycle pulse, entry refused for lack of space
- timeout_fault  out  1  one-cycle pulse, opened barrier not passed within PASS_TIMEOUT

## Operation
- Reset: state IDLE; all outputs 0; debouncer outputs and counters 0; latched class 0; pass timer 0. Reset mid-passage closes the barrier immediately and emits no event.
- Debounce: each loop input has an independent filter. The filter counts consecutive cycles where raw ≠ filtered. When the count reaches DEBOUNCE_CYCLES, the filtered output flips and the count clears. Any agreeing sample clears the count. FSM uses filtered signals only (din, dout).
- IDLE: din=1 → WAIT_CARD.
- WAIT_CARD: din=0 → IDLE. card_valid=1 → latch card_is_uni, then decide:
  - Entry gate, uni card: requires space_uni=1.
  - Entry gate, public card: requires space_public=1.
  - Space missing → REJECT.
  - Space present, or exit gate → OPEN, timer cleared.
- card_valid outside WAIT_CARD is ignored.
- REJECT: rejected=1 for exactly the first cycle in the state. Stay until din=0 → IDLE. Further cards are ignored.
- OPEN: barrier_open=1; timer increments each cycle.
  - dout=1 → PASSING.
  - Otherwise, timer reaches PASS_TIMEOUT → timeout_fault pulse, barrier closes, → REJECT-style hold: wait din=0, then IDLE. No rejected pulse in this case.
  - If both conditions hold in the same cycle, dout=1 wins.
- PASSING: barrier_open=1, no timeout. dout=0 → car_event=1 and is_uni_event=latched class for one cycle, → IDLE, barrier closes.
- Space flags are sampled only at the decision edge; later changes do not close an open barrier.
- Latched class stays unchanged from the decision until the next accepted card.

## Timing
- Raw loop edge that stays stable from edge k is reflected in the filtered signal after edge k+DEBOUNCE_CYCLES−1.
- Decision latency: card_valid sampled at edge n → barrier_open or rejected high after edge n (registered, 1 cycle).
- barrier_open drops and car_event rises on the same edge: the one after dout falls.
- All outputs registered; no combinational input→output paths.
- Back-to-back cars: after returning to IDLE with din still 1, the FSM reaches WAIT_CARD one cycle later. A new card is accepted no earlier than 2 cycles after car_event.
- At most one car_event per passage, even if dout bounces within the debounce window.

## Structure
- parking_pkg: gate state enum (IDLE, WAIT_CARD, REJECT, OPEN, PASSING, HOLD), default DEBOUNCE_CYCLES/PASS_TIMEOUT constants.
- Counter widths use $clog2(param+1).
- One sub-module, gate_debounce (parameter DEBOUNCE_CYCLES; ports clock, reset, raw, filtered), instantiated twice.

## Test plan
- Entry, uni card, space_uni=1: din high, card_valid with card_is_uni=1 → barrier_open next cycle. dout pulse of 10 cycles → one car_event with is_uni_event=1, barrier closes same edge.
- Entry, public card, space_public=0 → rejected high exactly 1 cycle, barrier_open stays 0. Releasing loop_in → IDLE after 4 cycles.
- Exit gate (IS_ENTRY=0), both space flags 0 → barrier opens; passage → car_event with is_uni_event=0.
- Barrier opened, no dout for 200 cycles → timeout_fault pulse on cycle 200, barrier closes, car_event never asserted.
- loop_out glitch of 3 cycles (< DEBOUNCE_CYCLES=4) while OPEN → no PASSING transition and no event. reset asserted in PASSING → next cycle all outputs 0 and no car_event.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CARD,
        REJECT,
        OPEN,
        PASSING,
        HOLD
    } gate_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_PASS_TIMEOUT    = 200;

    // Space flag relevant to the presented card class.
    function automatic logic space_ok(input logic is_uni,
                                      input logic space_uni,
                                      input logic space_public);
        return is_uni ? space_uni : space_public;
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Gate-side signal bundle: detectors, card reader, space flags and gate outputs.
interface parking_gate_ctrl_if;
    logic loop_in;
    logic loop_out;
    logic card_valid;
    logic card_is_uni;
    logic space_uni;
    logic space_public;
    logic barrier_open;
    logic car_event;
    logic is_uni_event;
    logic rejected;
    logic timeout_fault;

    // Driver side (gate hardware / testbench).
    modport master (
        output loop_in, loop_out, card_valid, card_is_uni, space_uni, space_public,
        input  barrier_open, car_event, is_uni_event, rejected, timeout_fault
    );

    // Controller side.
    modport slave (
        input  loop_in, loop_out, card_valid, card_is_uni, space_uni, space_public,
        output barrier_open, car_event, is_uni_event, rejected, timeout_fault
    );
endinterface

// File: rtl/gate_debounce.sv
// Loop detector filter: output flips only after DEBOUNCE_CYCLES consecutive
// disagreeing samples; any agreeing sample restarts the count.
module gate_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic filtered
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;

    // Count disagreements; flip when this sample completes the run.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (raw != filt_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = raw;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filtered = filt_q;
endmodule

// File: rtl/parking_gate_ctrl.sv
// Gate controller: debounced loops, card decision, barrier drive and one
// registered car_event per completed passage.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int IS_ENTRY        = 1,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int PASS_TIMEOUT    = DEFAULT_PASS_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    parking_gate_ctrl_if.slave gate
);
    localparam int TIMER_W = $clog2(PASS_TIMEOUT + 1);

    logic din, dout;

    gate_state_t        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
    logic               uni_q, uni_d;
    logic               barrier_q, barrier_d;
    logic               car_event_q, car_event_d;
    logic               is_uni_q, is_uni_d;
    logic               rejected_q, rejected_d;
    logic               timeout_q, timeout_d;

    gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_in (
        .clock    (clock),
        .reset    (reset),
        .raw      (gate.loop_in),
        .filtered (din)
    );

    gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_out (
        .clock    (clock),
        .reset    (reset),
        .raw      (gate.loop_out),
        .filtered (dout)
    );

    // Next state and next registered outputs; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        uni_d       = uni_q;
        barrier_d   = 1'b0;
        car_event_d = 1'b0;
        is_uni_d    = 1'b0;
        rejected_d  = 1'b0;
        timeout_d   = 1'b0;
        timer_inc   = timer_q + TIMER_W'(1);
        case (state_q)
            IDLE: begin
                if (din) state_d = WAIT_CARD;
            end
            WAIT_CARD: begin
                if (!din) begin
                    state_d = IDLE;
                end else if (gate.card_valid) begin
                    uni_d = gate.card_is_uni;
                    if ((IS_ENTRY != 0) &&
                        !space_ok(gate.card_is_uni, gate.space_uni, gate.space_public)) begin
                        state_d    = REJECT;
                        rejected_d = 1'b1;
                    end else begin
                        state_d   = OPEN;
                        timer_d   = '0;
                        barrier_d = 1'b1;
                    end
                end
            end
            REJECT, HOLD: begin
                if (!din) state_d = IDLE;
            end
            OPEN: begin
                timer_d   = timer_inc;
                barrier_d = 1'b1;
                // A car reaching the outer loop beats a simultaneous timeout.
                if (dout) begin
                    state_d = PASSING;
                end else if (timer_inc == TIMER_W'(PASS_TIMEOUT)) begin
                    state_d   = HOLD;
                    barrier_d = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            PASSING: begin
                if (!dout) begin
                    state_d     = IDLE;
                    car_event_d = 1'b1;
                    is_uni_d    = uni_q;
                end else begin
                    barrier_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer, latched class and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            uni_q       <= 1'b0;
            barrier_q   <= 1'b0;
            car_event_q <= 1'b0;
            is_uni_q    <= 1'b0;
            rejected_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            uni_q       <= uni_d;
            barrier_q   <= barrier_d;
            car_event_q <= car_event_d;
            is_uni_q    <= is_uni_d;
            rejected_q  <= rejected_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gate.barrier_open  = barrier_q;
    assign gate.car_event     = car_event_q;
    assign gate.is_uni_event  = is_uni_q;
    assign gate.rejected      = rejected_q;
    assign gate.timeout_fault = timeout_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboarded bench: one entry gate and one exit gate; expected pulses are
// queued as stimulus is applied and consumed by a negedge monitor.
module tb_parking_gate_ctrl;
    localparam int KIND_CAR = 0;
    localparam int KIND_REJ = 1;
    localparam int KIND_TO  = 2;

    typedef struct packed {
        logic       dut;
        logic [1:0] kind;
        logic       uni;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    parking_gate_ctrl_if ent_if ();
    parking_gate_ctrl_if ext_if ();

    parking_gate_ctrl #(.IS_ENTRY(1), .DEBOUNCE_CYCLES(4), .PASS_TIMEOUT(200)) u_entry (
        .clock (clock),
        .reset (reset),
        .gate  (ent_if)
    );

    parking_gate_ctrl #(.IS_ENTRY(0), .DEBOUNCE_CYCLES(4), .PASS_TIMEOUT(200)) u_exit (
        .clock (clock),
        .reset (reset),
        .gate  (ext_if)
    );

    logic [1:0] ce, iu, rj, tf, bo;
    logic [1:0] prev_bo = 2'b00;
    assign ce = {ext_if.car_event,     ent_if.car_event};
    assign iu = {ext_if.is_uni_event,  ent_if.is_uni_event};
    assign rj = {ext_if.rejected,      ent_if.rejected};
    assign tf = {ext_if.timeout_fault, ent_if.timeout_fault};
    assign bo = {ext_if.barrier_open,  ent_if.barrier_open};

    exp_t       mon_e;
    logic [1:0] mon_kind;
    logic       mon_ok;

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (iu[d] && !ce[d]) begin
                checks++;
                failures++;
                $display("FAIL is_uni_idle dut=%0d is_uni_event=1 required 0 without car_event", d);
            end
            if (ce[d] || rj[d] || tf[d]) begin
                checks++;
                mon_kind = ce[d] ? 2'(KIND_CAR) : (rj[d] ? 2'(KIND_REJ) : 2'(KIND_TO));
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse dut=%0d car=%0b rej=%0b to=%0b required none",
                             d, ce[d], rj[d], tf[d]);
                end else begin
                    mon_e  = sb.pop_front();
                    mon_ok = (mon_e.dut == 1'(d)) && (mon_e.kind == mon_kind) &&
                             ((32'(ce[d]) + 32'(rj[d]) + 32'(tf[d])) == 1);
                    if (mon_e.kind == 2'(KIND_CAR) && iu[d] !== mon_e.uni) mon_ok = 1'b0;
                    if (mon_e.kind == 2'(KIND_REJ) && bo[d] !== 1'b0) mon_ok = 1'b0;
                    if (mon_e.kind != 2'(KIND_REJ) && !(prev_bo[d] === 1'b1 && bo[d] === 1'b0))
                        mon_ok = 1'b0;
                    if (!mon_ok) begin
                        failures++;
                        $display("FAIL pulse_match dut=%0d got kind=%0d uni=%0b bar=%0b->%0b required dut=%0d kind=%0d uni=%0b",
                                 d, mon_kind, iu[d], prev_bo[d], bo[d], mon_e.dut, mon_e.kind, mon_e.uni);
                    end else begin
                        $display("event dut=%0d kind=%0d uni=%0b ok", d, mon_kind, iu[d]);
                    end
                end
            end
            prev_bo[d] = bo[d];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_loop_in(input int d, input logic v);
        if (d == 0) ent_if.loop_in = v; else ext_if.loop_in = v;
    endtask

    task automatic set_loop_out(input int d, input logic v);
        if (d == 0) ent_if.loop_out = v; else ext_if.loop_out = v;
    endtask

    // One-cycle card strobe; returns at the negedge after the decision edge.
    task automatic card(input int d, input logic uni);
        if (d == 0) begin ent_if.card_valid = 1'b1; ent_if.card_is_uni = uni; end
        else        begin ext_if.card_valid = 1'b1; ext_if.card_is_uni = uni; end
        tick(1);
        ent_if.card_valid = 1'b0;
        ext_if.card_valid = 1'b0;
    endtask

    function automatic logic bar(input int d);
        return (d == 0) ? ent_if.barrier_open : ext_if.barrier_open;
    endfunction

    task automatic check_bar(input string name, input int d, input logic exp);
        checks++;
        if (bar(d) !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d barrier_open=%0b required %0b", name, d, bar(d), exp);
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick(1);
        tick(1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s pending_events=%0d required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic passage(input int d, input int len);
        set_loop_out(d, 1'b1);
        tick(len);
        set_loop_out(d, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({ce, iu, rj, tf, bo} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs got %b required 0", {ce, iu, rj, tf, bo});
        end
        reset = 1'b0;
        tick(1);
        $display("test_reset done");
    endtask

    task automatic test_entry_uni();
        ent_if.space_uni = 1'b1;
        ent_if.space_public = 1'b0;
        card(0, 1'b1);
        check_bar("idle_card_ignored", 0, 1'b0);
        set_loop_in(0, 1'b1);
        tick(8);
        check_bar("wait_card_closed", 0, 1'b0);
        card(0, 1'b1);
        check_bar("uni_open", 0, 1'b1);
        sb.push_back('{dut: 1'b0, kind: 2'(KIND_CAR), uni: 1'b1});
        passage(0, 10);
        wait_empty("uni_event", 20);
        check_bar("uni_closed_after", 0, 1'b0);
        set_loop_in(0, 1'b0);
        tick(8);
        $display("test_entry_uni done");
    endtask

    task automatic test_reject();
        ent_if.space_uni = 1'b1;
        ent_if.space_public = 1'b0;
        set_loop_in(0, 1'b1);
        tick(8);
        sb.push_back('{dut: 1'b0, kind: 2'(KIND_REJ), uni: 1'b0});
        card(0, 1'b0);
        checks++;
        if (ent_if.rejected !== 1'b1) begin
            failures++;
            $display("FAIL reject_pulse rejected=%0b required 1", ent_if.rejected);
        end
        check_bar("reject_closed", 0, 1'b0);
        tick(1);
        checks++;
        if (ent_if.rejected !== 1'b0) begin
            failures++;
            $display("FAIL reject_width rejected=%0b required 0", ent_if.rejected);
        end
        card(0, 1'b1);
        check_bar("reject_card_ignored", 0, 1'b0);
        wait_empty("reject_event", 5);
        set_loop_in(0, 1'b0);
        tick(8);
        ent_if.space_public = 1'b1;
        set_loop_in(0, 1'b1);
        tick(8);
        card(0, 1'b0);
        check_bar("recover_open", 0, 1'b1);
        sb.push_back('{dut: 1'b0, kind: 2'(KIND_CAR), uni: 1'b0});
        passage(0, 6);
        wait_empty("public_event", 20);
        set_loop_in(0, 1'b0);
        tick(8);
        $display("test_reject done");
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        ent_if.space_uni = 1'b1;
        set_loop_in(0, 1'b1);
        tick(8);
        card(0, 1'b1);
        check_bar("b2b_first_open", 0, 1'b1);
        sb.push_back('{dut: 1'b0, kind: 2'(KIND_CAR), uni: 1'b1});
        passage(0, 6);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (ent_if.car_event === 1'b1) seen = 1;
            else tick(1);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL b2b_event_timeout car_event=0 required 1 within 20 cycles");
        end
        card(0, 1'b0);
        check_bar("b2b_early_card_ignored", 0, 1'b0);
        card(0, 1'b0);
        check_bar("b2b_second_open", 0, 1'b1);
        sb.push_back('{dut: 1'b0, kind: 2'(KIND_CAR), uni: 1'b0});
        passage(0, 6);
        wait_empty("b2b_events", 20);
        set_loop_in(0, 1'b0);
        tick(8);
        $display("test_back_to_back done");
    endtask

    task automatic test_exit();
        ext_if.space_uni = 1'b0;
        ext_if.space_public = 1'b0;
        set_loop_in(1, 1'b1);
        tick(8);
        card(1, 1'b0);
        check_bar("exit_open", 1, 1'b1);
        check_bar("exit_entry_idle", 0, 1'b0);
        sb.push_back('{dut: 1'b1, kind: 2'(KIND_CAR), uni: 1'b0});
        passage(1, 10);
        wait_empty("exit_event", 20);
        set_loop_in(1, 1'b0);
        tick(8);
        $display("test_exit done");
    endtask

    task automatic test_timeout();
        int n = 1;
        ent_if.space_uni = 1'b1;
        set_loop_in(0, 1'b1);
        tick(8);
        sb.push_back('{dut: 1'b0, kind: 2'(KIND_TO), uni: 1'b0});
        card(0, 1'b1);
        check_bar("timeout_open", 0, 1'b1);
        while (n < 300) begin
            tick(1);
            if (bar(0) !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != 200) begin
            failures++;
            $display("FAIL timeout_length open_cycles=%0d required 200", n);
        end
        wait_empty("timeout_event", 5);
        card(0, 1'b1);
        check_bar("hold_card_ignored", 0, 1'b0);
        set_loop_in(0, 1'b0);
        tick(8);
        $display("test_timeout done");
    endtask

    task automatic test_glitch_and_reset();
        ent_if.space_uni = 1'b1;
        set_loop_in(0, 1'b1);
        tick(8);
        card(0, 1'b1);
        check_bar("glitch_open", 0, 1'b1);
        passage(0, 3);
        tick(10);
        check_bar("glitch_still_open", 0, 1'b1);
        wait_empty("glitch_no_event", 1);
        set_loop_out(0, 1'b1);
        tick(8);
        reset = 1'b1;
        set_loop_out(0, 1'b0);
        set_loop_in(0, 1'b0);
        tick(1);
        checks++;
        if ({ce, iu, rj, tf, bo} !== 10'b0) begin
            failures++;
            $display("FAIL reset_passing outputs=%b required 0", {ce, iu, rj, tf, bo});
        end
        reset = 1'b0;
        tick(12);
        wait_empty("reset_no_event", 1);
        $display("test_glitch_and_reset done");
    endtask

    initial begin
        ent_if.loop_in = 1'b0; ent_if.loop_out = 1'b0; ent_if.card_valid = 1'b0;
        ent_if.card_is_uni = 1'b0; ent_if.space_uni = 1'b0; ent_if.space_public = 1'b0;
        ext_if.loop_in = 1'b0; ext_if.loop_out = 1'b0; ext_if.card_valid = 1'b0;
        ext_if.card_is_uni = 1'b0; ext_if.space_uni = 1'b0; ext_if.space_public = 1'b0;
        test_reset();
        test_entry_uni();
        test_reject();
        test_back_to_back();
        test_exit();
        test_timeout();
        test_glitch_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
